regfile_mp: RTL and testbench

Parametrised multi-port register file for the CPU decode/writeback stages. It provides N_READ combinational read ports and two write ports: A for ALU writeback, B for memory/load return. Same-cycle write-to-read bypass is built in. A per-register pending scoreboard flags load-use hazards. After reset, a sequential clear engine zeroes the array one entry per cycle, so the block maps onto distributed/block RAM without a parallel reset.

---
 rtl/regfile_mp.sv | 142 ++++++++++++++
 tb/tb_regfile_mp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file for decode/writeback.
// N_READ combinational read ports with same-cycle bypass from two write ports
// (B = load return, A = ALU; B wins on collision), a per-register pending
// scoreboard for load-use hazards, and a sequential clear engine that zeroes
// one entry per cycle after reset so the array needs no parallel reset.
//
// Handshake: there is no valid/ready pair. init_busy_o high means every
// write/reserve input is ignored and every read output is forced to 0; the
// core must stall until it falls. Once low, an enable is accepted on the
// posedge where it is sampled high.
module regfile_mp #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int N_READ    = 2,
   parameter int ZERO_REG  = 1,
   parameter int DEBUG_IDX = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       init_busy_o,
   input  logic [N_READ*ADDR_W-1:0]   rd_addr_i,
   output logic [N_READ*DATA_W-1:0]   rd_data_o,
   output logic [N_READ-1:0]          rd_pending_o,
   input  logic                       wa_en_i,
   input  logic [ADDR_W-1:0]          wa_addr_i,
   input  logic [DATA_W-1:0]          wa_data_i,
   input  logic                       wb_en_i,
   input  logic [ADDR_W-1:0]          wb_addr_i,
   input  logic [DATA_W-1:0]          wb_data_i,
   input  logic                       res_en_i,
   input  logic [ADDR_W-1:0]          res_addr_i,
   output logic [DATA_W-1:0]          debug_out_o,
   output logic                       state_o
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] DBG_ADDR = ADDR_W'(DEBUG_IDX);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DEPTH-1:0]    p_q;
   logic [DEPTH-1:0]    p_d;

   // run is false in any reset cycle, so nothing is written or reported then
   logic run;
   logic clear_we;
   logic wa_eff;
   logic wb_eff;
   logic res_eff;
   logic ab_same;

   assign run      = (state_q == S_RUN) && !rst;
   assign clear_we = (state_q == S_CLEAR) && !rst;
   assign wa_eff   = run && wa_en_i  && ((wa_addr_i  != '0) || (ZERO_REG == 0));
   assign wb_eff   = run && wb_en_i  && ((wb_addr_i  != '0) || (ZERO_REG == 0));
   assign res_eff  = run && res_en_i && ((res_addr_i != '0) || (ZERO_REG == 0));
   assign ab_same  = wa_addr_i == wb_addr_i;

   assign init_busy_o = rst || (state_q == S_CLEAR);
   assign state_o     = state_q;

   // Clear sequencer: walk cnt over every entry, then hand over to RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else if (state_q == S_CLEAR) begin
         cnt_q <= cnt_q + ADDR_W'(1);
         if (cnt_q == '1) begin
            state_q <= S_RUN;
         end
      end
   end

   // Array writes: clear port in CLEAR, else B then A (A dropped on collision).
   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem_q[cnt_q] <= '0;
      end else begin
         if (wb_eff) begin
            mem_q[wb_addr_i] <= wb_data_i;
         end
         if (wa_eff && !(wb_eff && ab_same)) begin
            mem_q[wa_addr_i] <= wa_data_i;
         end
      end
   end

   // Scoreboard next state: writes retire reservations, a new reservation wins.
   always_comb begin
      p_d = p_q;
      if (wa_eff) begin
         p_d[wa_addr_i] = 1'b0;
      end
      if (wb_eff) begin
         p_d[wb_addr_i] = 1'b0;
      end
      if (res_eff) begin
         p_d[res_addr_i] = 1'b1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   // Read ports: zero register, then B bypass, then A bypass, then array.
   for (genvar gi = 0; gi < N_READ; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              zero_hit;
      logic              hit_a;
      logic              hit_b;

      assign ra       = rd_addr_i[gi*ADDR_W +: ADDR_W];
      assign zero_hit = (ZERO_REG != 0) && (ra == '0);
      assign hit_a    = wa_eff && (wa_addr_i == ra);
      assign hit_b    = wb_eff && (wb_addr_i == ra);

      assign rd_data_o[gi*DATA_W +: DATA_W] =
         (!run || zero_hit) ? '0        :
         hit_b              ? wb_data_i :
         hit_a              ? wa_data_i :
                              mem_q[ra];

      assign rd_pending_o[gi] = run && p_q[ra] && !hit_a && !hit_b;
   end

   // Debug mirror shows stored content only; in-flight writes are not bypassed.
   assign debug_out_o = run ? mem_q[DBG_ADDR] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance, a ZERO_REG=0 twin sharing
// its inputs, and a narrow 16-bit / 8-entry / 4-read-port instance.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // default-parameter instance and its ZERO_REG=0 twin (shared inputs)
   logic        wa_en, wb_en, res_en;
   logic [4:0]  wa_addr, wb_addr, res_addr;
   logic [31:0] wa_data, wb_data;
   logic [9:0]  rd_addr;
   logic        busy, z_busy, st, z_st;
   logic [63:0] rd_data, z_rd_data;
   logic [1:0]  rd_pend, z_rd_pend;
   logic [31:0] dbg, z_dbg;

   // narrow instance
   logic        s_wa_en, s_wb_en, s_res_en;
   logic [2:0]  s_wa_addr, s_wb_addr, s_res_addr;
   logic [15:0] s_wa_data, s_wb_data;
   logic [11:0] s_rd_addr;
   logic        s_busy, s_st;
   logic [63:0] s_rd_data;
   logic [3:0]  s_rd_pend;
   logic [15:0] s_dbg;

   regfile_mp u_dut (
      .clk(clk), .rst(rst), .init_busy_o(busy),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_pending_o(rd_pend),
      .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
      .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .res_en_i(res_en), .res_addr_i(res_addr),
      .debug_out_o(dbg), .state_o(st)
   );

   regfile_mp #(.ZERO_REG(0)) u_z0 (
      .clk(clk), .rst(rst), .init_busy_o(z_busy),
      .rd_addr_i(rd_addr), .rd_data_o(z_rd_data), .rd_pending_o(z_rd_pend),
      .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
      .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .res_en_i(res_en), .res_addr_i(res_addr),
      .debug_out_o(z_dbg), .state_o(z_st)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .N_READ(4)) u_small (
      .clk(clk), .rst(rst), .init_busy_o(s_busy),
      .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data), .rd_pending_o(s_rd_pend),
      .wa_en_i(s_wa_en), .wa_addr_i(s_wa_addr), .wa_data_i(s_wa_data),
      .wb_en_i(s_wb_en), .wb_addr_i(s_wb_addr), .wb_data_i(s_wb_data),
      .res_en_i(s_res_en), .res_addr_i(s_res_addr),
      .debug_out_o(s_dbg), .state_o(s_st)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count negedges with busy high after rst has dropped; bounded.
   task automatic count_clear(input int exp_main, input int exp_small);
      int cm, cz, cs;
      cm = 0; cz = 0; cs = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!busy && !z_busy && !s_busy) break;
         if (busy) cm++;
         if (z_busy) cz++;
         if (s_busy) cs++;
         if (cm == 5) chk("busy_rd_zero", {rd_data, rd_pend, dbg}, '0);
         @(posedge clk);
         #1;
      end
      chk("clear_len", 64'(cm), 64'(exp_main));
      chk("clear_len_z0", 64'(cz), 64'(exp_main));
      chk("clear_len_small", 64'(cs), 64'(exp_small));
      chk("state_run", {st, z_st, s_st}, 64'h7);
      tick();
   endtask

   typedef struct {
      logic        wa_en;  logic [4:0] wa_addr; logic [31:0] wa_data;
      logic        wb_en;  logic [4:0] wb_addr; logic [31:0] wb_data;
      logic        res_en; logic [4:0] res_addr;
      logic [4:0]  ra0;    logic [4:0] ra1;
      logic [31:0] e_rd0;  logic [31:0] e_rd1; logic [1:0] e_pend;
      logic [31:0] e_dbg;  logic [31:0] e_zrd0; logic [1:0] e_zpend;
   } vec_t;

   vec_t vt[16];

   function automatic vec_t mk(
      input logic wae, input logic [4:0] waa, input logic [31:0] wad,
      input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
      input logic rse, input logic [4:0] rsa,
      input logic [4:0] r0, input logic [4:0] r1,
      input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] pd,
      input logic [31:0] dg, input logic [31:0] zd0, input logic [1:0] zpd);
      vec_t v;
      v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
      v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
      v.res_en = rse; v.res_addr = rsa;
      v.ra0 = r0; v.ra1 = r1;
      v.e_rd0 = d0; v.e_rd1 = d1; v.e_pend = pd;
      v.e_dbg = dg; v.e_zrd0 = zd0; v.e_zpend = zpd;
      return v;
   endfunction

   function automatic logic [15:0] sval(input int a);
      return 16'(16'h1000 + a * 16'h0111);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] s_exp;
      rst = 1'b1;
      wa_en = 1'b0; wa_addr = '0; wa_data = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      res_en = 1'b0; res_addr = '0; rd_addr = '0;
      s_wa_en = 1'b0; s_wa_addr = '0; s_wa_data = '0;
      s_wb_en = 1'b0; s_wb_addr = '0; s_wb_data = '0;
      s_res_en = 1'b0; s_res_addr = '0; s_rd_addr = '0;

      // power-up reset and first clear
      tick();
      tick();
      rst = 1'b0;
      count_clear(32, 8);

      // fill every register with ones, then prove the clear wipes them
      for (int r = 0; r < 32; r++) begin
         wa_en = 1'b1; wa_addr = 5'(r); wa_data = 32'hFFFF_FFFF;
         tick();
      end
      wa_en = 1'b0;
      rd_addr = {5'd17, 5'd31};
      @(negedge clk);
      chk("fill_read", rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();

      rst = 1'b1;
      @(negedge clk);
      chk("rst_cycle_busy", {63'd0, busy}, 64'd1);
      chk("rst_cycle_outs", {rd_data, rd_pend, dbg}, '0);
      tick();
      rst = 1'b0;
      count_clear(32, 8);

      for (int r = 0; r < 32; r++) begin
         rd_addr = {5'(r), 5'(r)};
         @(negedge clk);
         chk($sformatf("cleared_r%0d", r), {rd_data, z_rd_data}, '0);
         tick();
      end

      // restart mid-clear; a reservation made during clear must be ignored
      rst = 1'b1;
      tick();
      rst = 1'b0;
      res_en = 1'b1; res_addr = 5'd9;
      repeat (10) tick();
      res_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_clear(32, 8);
      rd_addr = {5'd9, 5'd9};
      @(negedge clk);
      chk("res_in_clear_ignored", {62'd0, rd_pend}, 64'd0);
      tick();

      // table-driven RUN vectors
      vt[0]  = mk(1'b1,5'd3,32'h12345678, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd3,5'd1,
                  32'h12345678,32'h0,2'b00, 32'h0,32'h12345678,2'b00);
      vt[1]  = mk(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd3,5'd3,
                  32'h12345678,32'h12345678,2'b00, 32'h0,32'h12345678,2'b00);
      vt[2]  = mk(1'b1,5'd5,32'h1, 1'b1,5'd5,32'h2, 1'b0,5'd0, 5'd5,5'd6,
                  32'h2,32'h0,2'b00, 32'h0,32'h2,2'b00);
      vt[3]  = mk(1'b1,5'd6,32'hA6, 1'b1,5'd9,32'hB9, 1'b0,5'd0, 5'd5,5'd6,
                  32'h2,32'hA6,2'b00, 32'h0,32'h2,2'b00);
      vt[4]  = mk(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd6,5'd9,
                  32'hA6,32'hB9,2'b00, 32'h0,32'hA6,2'b00);
      vt[5]  = mk(1'b1,5'd0,32'hDEAD, 1'b1,5'd0,32'hDEAD, 1'b1,5'd0, 5'd0,5'd0,
                  32'h0,32'h0,2'b00, 32'h0,32'hDEAD,2'b00);
      vt[6]  = mk(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd0,
                  32'h0,32'h0,2'b00, 32'h0,32'hDEAD,2'b11);
      vt[7]  = mk(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd4, 5'd4,5'd3,
                  32'h0,32'h12345678,2'b00, 32'h0,32'h0,2'b00);
      vt[8]  = mk(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd5,
                  32'h0,32'h2,2'b01, 32'h0,32'h0,2'b01);
      vt[9]  = mk(1'b0,5'd0,32'h0, 1'b1,5'd4,32'h44, 1'b0,5'd0, 5'd4,5'd4,
                  32'h44,32'h44,2'b00, 32'h0,32'h44,2'b00);
      vt[10] = mk(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd4,
                  32'h44,32'h44,2'b00, 32'h0,32'h44,2'b00);
      vt[11] = mk(1'b1,5'd4,32'h55, 1'b0,5'd0,32'h0, 1'b1,5'd4, 5'd4,5'd9,
                  32'h55,32'hB9,2'b00, 32'h0,32'h55,2'b00);
      vt[12] = mk(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd9,
                  32'h55,32'hB9,2'b01, 32'h0,32'h55,2'b01);
      vt[13] = mk(1'b1,5'd7,32'h77, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd4,5'd7,
                  32'h55,32'h77,2'b01, 32'h0,32'h55,2'b01);
      vt[14] = mk(1'b1,5'd5,32'h1, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd5,
                  32'h77,32'h1,2'b00, 32'h77,32'h77,2'b00);
      vt[15] = mk(1'b0,5'd0,32'h0, 1'b1,5'd8,32'h88, 1'b0,5'd0, 5'd8,5'd4,
                  32'h88,32'h55,2'b10, 32'h77,32'h88,2'b10);

      for (int i = 0; i < 16; i++) begin
         wa_en = vt[i].wa_en; wa_addr = vt[i].wa_addr; wa_data = vt[i].wa_data;
         wb_en = vt[i].wb_en; wb_addr = vt[i].wb_addr; wb_data = vt[i].wb_data;
         res_en = vt[i].res_en; res_addr = vt[i].res_addr;
         rd_addr = {vt[i].ra1, vt[i].ra0};
         @(negedge clk);
         chk($sformatf("v%0d rd0", i), 64'(rd_data[31:0]), 64'(vt[i].e_rd0));
         chk($sformatf("v%0d rd1", i), 64'(rd_data[63:32]), 64'(vt[i].e_rd1));
         chk($sformatf("v%0d pend", i), 64'(rd_pend), 64'(vt[i].e_pend));
         chk($sformatf("v%0d dbg", i), {32'(dbg), 32'(z_dbg)}, {vt[i].e_dbg, vt[i].e_dbg});
         chk($sformatf("v%0d z_rd0", i), 64'(z_rd_data[31:0]), 64'(vt[i].e_zrd0));
         chk($sformatf("v%0d z_pend", i), 64'(z_rd_pend), 64'(vt[i].e_zpend));
         tick();
      end
      wa_en = 1'b0; wb_en = 1'b0; res_en = 1'b0;

      // narrow instance: distinct values, four independent reads, debug on r7
      for (int a = 1; a < 8; a++) begin
         s_wa_en = 1'b1; s_wa_addr = 3'(a); s_wa_data = sval(a);
         tick();
      end
      s_wa_en = 1'b0;
      s_rd_addr = {3'd7, 3'd3, 3'd2, 3'd1};
      s_exp = {sval(7), sval(3), sval(2), sval(1)};
      @(negedge clk);
      chk("small_rd4", s_rd_data, s_exp);
      chk("small_dbg", 64'(s_dbg), 64'(sval(7)));
      chk("small_pend", 64'(s_rd_pend), 64'd0);
      tick();

      // collision on r7: port 3 bypasses B, debug keeps the stored value
      s_wa_en = 1'b1; s_wa_addr = 3'd7; s_wa_data = 16'hAAAA;
      s_wb_en = 1'b1; s_wb_addr = 3'd7; s_wb_data = 16'hBBBB;
      @(negedge clk);
      chk("small_bypass", s_rd_data, {16'hBBBB, sval(3), sval(2), sval(1)});
      chk("small_dbg_nobypass", 64'(s_dbg), 64'(sval(7)));
      tick();
      s_wa_en = 1'b0; s_wb_en = 1'b0;
      @(negedge clk);
      chk("small_dbg_after", 64'(s_dbg), 64'h0000_0000_0000_BBBB);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
